// File: rtl/fifo_rd_pkg.sv
// Shared defaults and types for the FIFO read-side packer.
package fifo_rd_pkg;

  localparam int DSIZE_DEF  = 8;
  localparam int PACK_N_DEF = 4;

  typedef logic [DSIZE_DEF-1:0]              word_t;
  typedef logic [$clog2(PACK_N_DEF+1)-1:0]   lane_cnt_t;
  typedef logic [PACK_N_DEF-1:0]             keep_t;

  localparam keep_t KEEP_FULL = '1;

endpackage

// File: rtl/fifo_rd_outreg.sv
// Output holding register for a valid/ready stream: loads a new beat whenever
// the slot is empty or being consumed, otherwise holds data and keep stable.
module fifo_rd_outreg #(
  parameter int DW = 32,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic [KW-1:0] load_keep,
  input  logic          m_ready,
  output logic          can_load,
  output logic [DW-1:0] m_data,
  output logic [KW-1:0] m_keep,
  output logic          m_valid
);

  logic [DW-1:0] data_q, data_d;
  logic [KW-1:0] keep_q, keep_d;
  logic          valid_q, valid_d;

  assign can_load = !valid_q || m_ready;

  // The caller only asserts load when can_load is true, so a load always
  // replaces either an empty slot or a beat being accepted this cycle.
  always_comb begin
    data_d  = data_q;
    keep_d  = keep_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      keep_d  = load_keep;
      valid_d = 1'b1;
    end else if (valid_q && m_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
    end
  end

  assign m_data  = data_q;
  assign m_keep  = keep_q;
  assign m_valid = valid_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains an async-FIFO read port and packs PACK_N words per output beat.
// Optional partial-beat flush after TIMEOUT idle cycles: FIFO_RD_PACKER_FLUSH_TIMEOUT_EN.
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE   = DSIZE_DEF,
  parameter int PACK_N  = PACK_N_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                    rclk,
  input  logic                    rrst,
  input  logic                    rempty,
  input  logic [DSIZE-1:0]        rdata,
  output logic                    rinc,
  output logic [DSIZE*PACK_N-1:0] m_data,
  output logic [PACK_N-1:0]       m_keep,
  output logic                    m_valid,
  input  logic                    m_ready
);

  localparam int LCW = $clog2(PACK_N+1);
  localparam logic [LCW-1:0] LANE_FULL = LCW'(PACK_N);

  if (PACK_N < 2 || TIMEOUT < 1) begin : g_cfg_check
    $error("fifo_rd_packer: PACK_N must be >= 2 and TIMEOUT >= 1");
  end

  logic [DSIZE-1:0]        acc_q [PACK_N];
  logic [DSIZE-1:0]        acc_d [PACK_N];
  logic [LCW-1:0]          lane_cnt_q, lane_cnt_d;
  logic [LCW-1:0]          base;
  logic                    can_load;
  logic                    xfer;
  logic                    flush;
  logic                    emit;
  logic [DSIZE*PACK_N-1:0] load_data;
  logic [PACK_N-1:0]       load_keep;

  assign xfer = (lane_cnt_q == LANE_FULL) && can_load;
  assign rinc = !rrst && !rempty && ((lane_cnt_q < LANE_FULL) || xfer);
  assign emit = xfer || flush;
  // A beat leaving this cycle frees lane 0 for a word popped in the same cycle.
  assign base = emit ? '0 : lane_cnt_q;

  always_comb begin
    lane_cnt_d = base;
    if (rinc) lane_cnt_d = base + LCW'(1);
  end

  always_comb begin
    for (int i = 0; i < PACK_N; i++) begin
      acc_d[i] = acc_q[i];
      if (rinc && (LCW'(i) == base)) acc_d[i] = rdata;
    end
  end

  always_comb begin
    load_data = '0;
    load_keep = '0;
    for (int i = 0; i < PACK_N; i++) begin
`ifdef FIFO_RD_PACKER_FLUSH_TIMEOUT_EN
      load_keep[i] = (LCW'(i) < lane_cnt_q);
`else
      load_keep[i] = 1'b1;
`endif
      if (load_keep[i]) load_data[i*DSIZE +: DSIZE] = acc_q[i];
    end
  end

`ifdef FIFO_RD_PACKER_FLUSH_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT+1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

  logic [IW-1:0] idle_q, idle_d;

  // A full accumulator never flushes: it either transfers or is back-pressured.
  assign flush = !xfer && (lane_cnt_q != '0) && (idle_q == IDLE_MAX) && can_load;

  always_comb begin
    idle_d = idle_q;
    if (rinc || emit)
      idle_d = '0;
    else if ((lane_cnt_q != '0) && (idle_q != IDLE_MAX))
      idle_d = idle_q + IW'(1);
  end

  always_ff @(posedge rclk) begin
    if (rrst) idle_q <= '0;
    else      idle_q <= idle_d;
  end
`else
  assign flush = 1'b0;
`endif

  always_ff @(posedge rclk) begin
    if (rrst) lane_cnt_q <= '0;
    else      lane_cnt_q <= lane_cnt_d;
  end

  always_ff @(posedge rclk) begin
    acc_q <= acc_d;
  end

  fifo_rd_outreg #(
    .DW (DSIZE*PACK_N),
    .KW (PACK_N)
  ) u_outreg (
    .clk       (rclk),
    .rst       (rrst),
    .load      (emit),
    .load_data (load_data),
    .load_keep (load_keep),
    .m_ready   (m_ready),
    .can_load  (can_load),
    .m_data    (m_data),
    .m_keep    (m_keep),
    .m_valid   (m_valid)
  );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer (DSIZE=8, PACK_N=4) with a behavioural FIFO read port.
module tb_fifo_rd_packer;
  import fifo_rd_pkg::*;

  logic        clk;
  logic        rrst;
  logic        rempty;
  word_t       rdata;
  logic        rinc;
  logic [31:0] m_data;
  keep_t       m_keep;
  logic        m_valid;
  logic        m_ready;

  int checks = 0;
  int errors = 0;

  fifo_rd_packer #(.DSIZE(8), .PACK_N(4), .TIMEOUT(16)) dut (
    .rclk    (clk),
    .rrst    (rrst),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  word_t mem [64];
  int    wr_ptr = 0;
  int    rd_ptr = 0;
  bit    force_empty = 1'b0;
  int    pops = 0;
  int    bad_pops = 0;

  assign rempty = force_empty || (wr_ptr == rd_ptr);
  assign rdata  = mem[rd_ptr[5:0]];

  always @(posedge clk) begin : pop_model
    logic p, e;
    p = rinc;
    e = rempty;
    if (p === 1'b1) begin
      #1;
      if (e) bad_pops <= bad_pops + 1;
      else begin
        rd_ptr <= rd_ptr + 1;
        pops   <= pops + 1;
      end
    end
  end

  int          cyc = 0;
  int          beat_n = 0;
  logic [31:0] beat_data [64];
  keep_t       beat_keep [64];
  int          beat_cyc  [64];

  always @(posedge clk) begin
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      beat_data[beat_n[5:0]] <= m_data;
      beat_keep[beat_n[5:0]] <= m_keep;
      beat_cyc[beat_n[5:0]]  <= cyc;
      beat_n <= beat_n + 1;
    end
    cyc <= cyc + 1;
  end

  task automatic push(input word_t w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rrst = 1'b1; m_ready = 1'b0; force_empty = 1'b0;
    push(8'h55);
    #1;
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc got %b want 0", rinc); end
    step(); step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", m_valid); end
    checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", m_data); end
    checks++; if (m_keep !== 4'h0) begin errors++; $display("FAIL reset_keep got %h want 0", m_keep); end
    wr_ptr = rd_ptr;
    rrst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [7:0]  rinc_v, mv_v;
    logic [31:0] d5;
    keep_t       k5;
    d5 = '0; k5 = '0;
    m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    #1;
    for (int c = 0; c < 8; c++) begin
      rinc_v[c] = rinc;
      mv_v[c]   = m_valid;
      if (c == 5) begin d5 = m_data; k5 = m_keep; end
      step();
    end
    checks++; if (rinc_v !== 8'b0000_1111) begin errors++; $display("FAIL basic_rinc_pattern got %b want 00001111", rinc_v); end
    checks++; if (mv_v !== 8'b0010_0000) begin errors++; $display("FAIL basic_valid_pattern got %b want 00100000", mv_v); end
    checks++; if (d5 !== 32'h44332211) begin errors++; $display("FAIL basic_data got %h want 44332211", d5); end
    checks++; if (k5 !== KEEP_FULL) begin errors++; $display("FAIL basic_keep got %h want f", k5); end
  endtask

  task automatic test_back_pressure();
    int p0, b0;
    logic [31:0] d6;
    p0 = pops; b0 = beat_n; d6 = '0;
    m_ready = 1'b0;
    for (int w = 1; w <= 12; w++) push(word_t'(w));
    #1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 6) d6 = m_data;
    end
    checks++; if (d6 !== 32'h04030201) begin errors++; $display("FAIL bp_data_early got %h want 04030201", d6); end
    checks++; if (pops - p0 !== 8) begin errors++; $display("FAIL bp_pops_stalled got %0d want 8", pops - p0); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held got %b want 1", m_valid); end
    checks++; if (m_data !== 32'h04030201) begin errors++; $display("FAIL bp_data_held got %h want 04030201", m_data); end
    checks++; if (m_keep !== 4'hF) begin errors++; $display("FAIL bp_keep_held got %h want f", m_keep); end
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL bp_rinc_stalled got %b want 0", rinc); end
    m_ready = 1'b1;
    step();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_b2b_valid got %b want 1", m_valid); end
    checks++; if (m_data !== 32'h08070605) begin errors++; $display("FAIL bp_b2b_data got %h want 08070605", m_data); end
    repeat (12) step();
    checks++; if (beat_n - b0 !== 3) begin errors++; $display("FAIL bp_beat_count got %0d want 3", beat_n - b0); end
    checks++; if (beat_data[b0] !== 32'h04030201) begin errors++; $display("FAIL bp_beat0 got %h want 04030201", beat_data[b0]); end
    checks++; if (beat_data[b0+1] !== 32'h08070605) begin errors++; $display("FAIL bp_beat1 got %h want 08070605", beat_data[b0+1]); end
    checks++; if (beat_data[b0+2] !== 32'h0C0B0A09) begin errors++; $display("FAIL bp_beat2 got %h want 0c0b0a09", beat_data[b0+2]); end
    checks++; if (beat_cyc[b0+1] - beat_cyc[b0] !== 1) begin errors++; $display("FAIL bp_b2b_spacing got %0d want 1", beat_cyc[b0+1] - beat_cyc[b0]); end
    checks++; if (pops - p0 !== 12) begin errors++; $display("FAIL bp_pops_total got %0d want 12", pops - p0); end
  endtask

  task automatic test_streaming();
    int p0, b0, rcount;
    logic [31:0] exp_beats [5];
    exp_beats = '{32'h23222120, 32'h27262524, 32'h2B2A2928, 32'h2F2E2D2C, 32'h33323130};
    p0 = pops; b0 = beat_n; rcount = 0;
    m_ready = 1'b1;
    for (int w = 8'h20; w <= 8'h33; w++) push(word_t'(w));
    #1;
    for (int c = 0; c < 20; c++) begin
      if (rinc === 1'b1) rcount++;
      step();
    end
    checks++; if (rcount !== 20) begin errors++; $display("FAIL stream_rinc_cycles got %0d want 20", rcount); end
    repeat (10) step();
    checks++; if (beat_n - b0 !== 5) begin errors++; $display("FAIL stream_beat_count got %0d want 5", beat_n - b0); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (beat_data[b0+i] !== exp_beats[i]) begin errors++; $display("FAIL stream_beat%0d_data got %h want %h", i, beat_data[b0+i], exp_beats[i]); end
      checks++; if (beat_keep[b0+i] !== 4'hF) begin errors++; $display("FAIL stream_beat%0d_keep got %h want f", i, beat_keep[b0+i]); end
      if (i > 0) begin
        checks++; if (beat_cyc[b0+i] - beat_cyc[b0+i-1] !== 4) begin errors++; $display("FAIL stream_spacing%0d got %0d want 4", i, beat_cyc[b0+i] - beat_cyc[b0+i-1]); end
      end
    end
    checks++; if (pops - p0 !== 20) begin errors++; $display("FAIL stream_pops got %0d want 20", pops - p0); end
  endtask

`ifndef FIFO_RD_PACKER_FLUSH_TIMEOUT_EN
  task automatic test_empty_gating();
    int p0, b0, rc, vc;
    p0 = pops; b0 = beat_n; rc = 0; vc = 0;
    m_ready = 1'b1;
    push(8'h61); push(8'h62);
    #1;
    repeat (3) step();
    force_empty = 1'b1;
    push(8'h63); push(8'h64);
    #1;
    for (int c = 0; c < 50; c++) begin
      if (rinc !== 1'b0) rc++;
      if (m_valid !== 1'b0) vc++;
      step();
    end
    checks++; if (rc !== 0) begin errors++; $display("FAIL empty_rinc_cycles got %0d want 0", rc); end
    checks++; if (vc !== 0) begin errors++; $display("FAIL empty_valid_cycles got %0d want 0", vc); end
    checks++; if (pops - p0 !== 2) begin errors++; $display("FAIL empty_pops got %0d want 2", pops - p0); end
    force_empty = 1'b0;
    repeat (8) step();
    checks++; if (beat_n - b0 !== 1) begin errors++; $display("FAIL empty_resume_count got %0d want 1", beat_n - b0); end
    checks++; if (beat_data[b0] !== 32'h64636261) begin errors++; $display("FAIL empty_resume_data got %h want 64636261", beat_data[b0]); end
  endtask
`else
  task automatic test_flush();
    int first;
    logic [31:0] fd;
    keep_t fk;
    first = -1; fd = '0; fk = '0;
    m_ready = 1'b1;
    push(8'hAA); push(8'hBB);
    #1;
    for (int c = 0; c <= 30; c++) begin
      if (m_valid === 1'b1 && first < 0) begin first = c; fd = m_data; fk = m_keep; end
      step();
    end
    checks++; if (first !== 19) begin errors++; $display("FAIL flush_cycle got %0d want 19", first); end
    checks++; if (fd !== 32'h0000BBAA) begin errors++; $display("FAIL flush_data got %h want 0000bbaa", fd); end
    checks++; if (fk !== 4'h3) begin errors++; $display("FAIL flush_keep got %h want 3", fk); end
  endtask
`endif

  task automatic test_reset_mid();
    int p0, p1, b0;
    p0 = pops; b0 = beat_n;
    m_ready = 1'b0;
    push(8'h91); push(8'h92); push(8'h93); push(8'h94);
    push(8'h71); push(8'h72); push(8'h73);
    #1;
    repeat (10) step();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rmid_pending_valid got %b want 1", m_valid); end
    checks++; if (m_data !== 32'h94939291) begin errors++; $display("FAIL rmid_pending_data got %h want 94939291", m_data); end
    checks++; if (pops - p0 !== 7) begin errors++; $display("FAIL rmid_pops_before got %0d want 7", pops - p0); end
    p1 = pops;
    rrst = 1'b1;
    push(8'h81); push(8'h82); push(8'h83); push(8'h84);
    #1;
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL rmid_rinc_in_reset got %b want 0", rinc); end
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", m_valid); end
    checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL rmid_data got %h want 00000000", m_data); end
    checks++; if (m_keep !== 4'h0) begin errors++; $display("FAIL rmid_keep got %h want 0", m_keep); end
    checks++; if (pops !== p1) begin errors++; $display("FAIL rmid_no_pop got %0d want %0d", pops, p1); end
    rrst = 1'b0;
    m_ready = 1'b1;
    #1;
    repeat (10) step();
    checks++; if (beat_n - b0 !== 1) begin errors++; $display("FAIL rmid_beat_count got %0d want 1", beat_n - b0); end
    checks++; if (beat_data[b0] !== 32'h84838281) begin errors++; $display("FAIL rmid_fresh_data got %h want 84838281", beat_data[b0]); end
    checks++; if (beat_keep[b0] !== 4'hF) begin errors++; $display("FAIL rmid_fresh_keep got %h want f", beat_keep[b0]); end
  endtask

  initial begin
    rrst = 1'b1;
    m_ready = 1'b0;
    test_reset();
    test_basic();
    test_back_pressure();
    test_streaming();
`ifndef FIFO_RD_PACKER_FLUSH_TIMEOUT_EN
    test_empty_gating();
`else
    test_flush();
`endif
    test_reset_mid();
    checks++; if (bad_pops !== 0) begin errors++; $display("FAIL pop_while_empty got %0d want 0", bad_pops); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
